// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached command RAM: word widths,
// opcode encoding carried in din[9:8], and control FSM states.
package spi_ram_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/ram_sp_array.sv
// Single-port synchronous RAM: one shared address for read and write,
// registered read data, no reset on the storage so it maps to block RAM.
module ram_sp_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous write and registered read on the shared port.
  // NOTE: the array has no reset; adding one would prevent block-RAM
  // inference and contents are allowed to be undefined after power-up.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM behind an SPI slave. Each accepted 10-bit word is
// registered, then decoded one cycle later into a pointer update, a memory
// write, or a read response (dout + one-cycle tx_valid).
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              addr_err
);

  logic                 rx_valid_q;
  logic                 accept;
  logic                 rd_req;
  logic                 cmd_vld_q;
  opcode_e              cmd_op_q;
  logic [DATA_W-1:0]    cmd_pay_q;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic                 ram_we;
  logic [DATA_W-1:0]    ram_rdata;
  logic                 rd_cmd;
  state_e               state_q;
  state_e               state_d;

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] p);
    return 32'(p) < MEM_DEPTH;
  endfunction

  function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
    return (32'(p) == MEM_DEPTH - 1) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  // Rising edge of rx_valid accepts exactly one command per assertion.
  assign accept = rx_valid & ~rx_valid_q;

  // A read is launched on the accept edge itself so the registered RAM
  // output is ready when the command is decoded one cycle later. A write
  // happens on the decode edge; the two can never share a cycle because
  // accepts are at least two cycles apart.
  assign rd_req   = accept && (opcode_e'(din[9:8]) == OP_RD_DATA);
  assign ram_addr = rd_req ? rd_ptr : wr_ptr;
  assign ram_we   = cmd_vld_q && (cmd_op_q == OP_WR_DATA) && in_range(wr_ptr);
  assign rd_cmd   = cmd_vld_q && (cmd_op_q == OP_RD_DATA);

  ram_sp_array #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_SIZE),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cmd_pay_q),
    .rdata (ram_rdata)
  );

  // Edge detect, command register, pointer update, range check and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      cmd_vld_q  <= 1'b0;
      cmd_op_q   <= OP_WR_ADDR;
      cmd_pay_q  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      addr_err   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      cmd_vld_q  <= accept;
      if (accept) begin
        cmd_op_q  <= opcode_e'(din[9:8]);
        cmd_pay_q <= din[7:0];
      end
      if (cmd_vld_q) begin
        case (cmd_op_q)
          OP_WR_ADDR: wr_ptr <= cmd_pay_q;
          OP_WR_DATA: begin
            if (!in_range(wr_ptr)) addr_err <= 1'b1;
            if (AUTO_INC != 0)     wr_ptr   <= next_ptr(wr_ptr);
          end
          OP_RD_ADDR: rd_ptr <= cmd_pay_q;
          OP_RD_DATA: begin
            if (in_range(rd_ptr)) begin
              dout <= ram_rdata;
            end else begin
              dout     <= '0;
              addr_err <= 1'b1;
            end
            if (AUTO_INC != 0) rd_ptr <= next_ptr(rd_ptr);
          end
          default: ;
        endcase
      end
    end
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and response strobe; any decoded read enters RESP.
  // NOTE: combinational logic uses blocking assignments, and every output
  // gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d  = ST_IDLE;
    tx_valid = 1'b0;
    case (state_q)
      ST_IDLE: if (rd_cmd) state_d = ST_RESP;
      ST_RESP: begin
        tx_valid = 1'b1;
        if (rd_cmd) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench: two instances (256 deep with auto-increment, 200 deep
// without) share one stimulus stream and are compared against a behavioural
// command-level model kept per instance.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  localparam int DEPTH_A = 256;
  localparam int DEPTH_B = 200;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [9:0] din      = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout_s  [2];
  logic       tx_s    [2];
  logic       err_s   [2];

  spi_ram_ctrl #(.MEM_DEPTH(DEPTH_A), .ADDR_SIZE(8), .AUTO_INC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_s[0]), .tx_valid(tx_s[0]), .addr_err(err_s[0])
  );

  spi_ram_ctrl #(.MEM_DEPTH(DEPTH_B), .ADDR_SIZE(8), .AUTO_INC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_s[1]), .tx_valid(tx_s[1]), .addr_err(err_s[1])
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state, one set per instance.
  string      m_name [2];
  int         m_depth [2];
  bit         m_auto [2];
  int         m_wr [2];
  int         m_rd [2];
  bit         m_err [2];
  logic [7:0] m_dout [2];
  bit         m_dout_known [2];
  logic [7:0] m_mem [2][256];
  bit         m_known [2][256];
  bit         m_rd_cmd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bump(input int p, input int depth);
    return (p == depth - 1) ? 0 : (p + 1) % 256;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_wr[i]         = 0;
      m_rd[i]         = 0;
      m_err[i]        = 1'b0;
      m_dout[i]       = 8'h00;
      m_dout_known[i] = 1'b1;
    end
    m_rd_cmd = 1'b0;
  endtask

  task automatic m_apply(input logic [9:0] w);
    int pay;
    pay = int'(w[7:0]);
    m_rd_cmd = (w[9:8] == 2'b11);
    for (int i = 0; i < 2; i++) begin
      case (w[9:8])
        2'b00: m_wr[i] = pay;
        2'b01: begin
          if (m_wr[i] < m_depth[i]) begin
            m_mem[i][m_wr[i]]   = w[7:0];
            m_known[i][m_wr[i]] = 1'b1;
          end else begin
            m_err[i] = 1'b1;
          end
          if (m_auto[i]) m_wr[i] = bump(m_wr[i], m_depth[i]);
        end
        2'b10: m_rd[i] = pay;
        default: begin
          if (m_rd[i] < m_depth[i]) begin
            m_dout[i]       = m_mem[i][m_rd[i]];
            m_dout_known[i] = m_known[i][m_rd[i]];
          end else begin
            m_dout[i]       = 8'h00;
            m_dout_known[i] = 1'b1;
            m_err[i]        = 1'b1;
          end
          if (m_auto[i]) m_rd[i] = bump(m_rd[i], m_depth[i]);
        end
      endcase
    end
  endtask

  // Compare every output of both instances against the model; first marks
  // the single cycle in which a read response pulse is due.
  task automatic check_cycle(input bit first);
    for (int i = 0; i < 2; i++) begin
      check({"tx_", m_name[i]}, 32'(tx_s[i]), 32'(first && m_rd_cmd));
      check({"err_", m_name[i]}, 32'(err_s[i]), 32'(m_err[i]));
      if (m_dout_known[i]) check({"dout_", m_name[i]}, 32'(dout_s[i]), 32'(m_dout[i]));
    end
  endtask

  // Present one command, holding rx_valid for 'hold' rising edges, and check
  // the response cycle plus the cycles that follow it.
  task automatic send(input logic [9:0] w, input int hold = 1);
    @(negedge clk);
    din      = w;
    rx_valid = 1'b1;
    m_apply(w);
    for (int c = 0; c < hold + 2; c++) begin
      @(posedge clk);
      #1;
      if (c == hold - 1) rx_valid = 1'b0;
      if (c >= 1) check_cycle(c == 1);
    end
  endtask

  // Assert reset mid-cycle, check outputs clear at once, then check that no
  // response appears for five cycles after release.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_cycle(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_cycle(1'b0);
    end
  endtask

  task automatic send_random();
    logic [1:0] op;
    logic [7:0] pay;
    op  = 2'($urandom_range(0, 3));
    pay = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
    send({op, pay}, ($urandom_range(0, 5) == 0) ? 3 : 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_name  = '{"a", "b"};
    m_depth = '{DEPTH_A, DEPTH_B};
    m_auto  = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) m_known[i][a] = 1'b0;
    m_reset();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_cycle(1'b0);

    // Give low addresses known contents in both instances.
    for (int a = 0; a < 16; a++) begin
      send({OP_WR_ADDR, 8'(a)});
      send({OP_WR_DATA, 8'($urandom_range(0, 255))});
    end

    // Basic write then read.
    send(10'h012);
    send(10'h1A5);
    send(10'h212);
    send(10'h300);
    for (int i = 0; i < 2; i++) begin
      check({"basic_dout_", m_name[i]}, 32'(dout_s[i]), 32'h0A5);
      check({"basic_err_", m_name[i]}, 32'(err_s[i]), 32'h0);
    end

    // Reset mid-cycle with non-zero dout.
    do_reset();

    // Held rx_valid gives exactly one response.
    send(10'h300, 4);

    // Auto-increment wrap at the top of a 256-deep array.
    send(10'h0FF);
    send(10'h111);
    send(10'h122);
    send(10'h2FF);
    send(10'h300);
    check("wrap_rd0_a", 32'(dout_s[0]), 32'h011);
    send(10'h300);
    check("wrap_rd1_a", 32'(dout_s[0]), 32'h022);
    check("wrap_err_b", 32'(err_s[1]), 32'h1);

    do_reset();

    // Out-of-range access on the 200-deep instance.
    send(10'h0C8);
    send(10'h155);
    send(10'h2C8);
    send(10'h300);
    check("oor_dout_b", 32'(dout_s[1]), 32'h000);
    check("oor_err_b", 32'(err_s[1]), 32'h1);
    check("oor_dout_a", 32'(dout_s[0]), 32'h055);
    repeat (4) @(posedge clk);
    #1;
    check("oor_sticky_b", 32'(err_s[1]), 32'h1);

    // Randomised command stream with occasional resets.
    repeat (150) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      send_random();
    end

    // Reset during the response cycle.
    send(10'h000);
    send(10'h13C);
    send(10'h205);
    @(negedge clk);
    din      = 10'h300;
    rx_valid = 1'b1;
    m_apply(din);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check({"mid_tx_", m_name[i]}, 32'(tx_s[i]), 32'h1);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_cycle(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_cycle(1'b0);
    end
    send(10'h300);
    for (int i = 0; i < 2; i++) check({"rst_rd_mem0_", m_name[i]}, 32'(dout_s[i]), 32'h03C);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Command-decoding single-port RAM that sits directly downstream of the SPI slave. It consumes each 10-bit parallel word the slave delivers (`rx_data`/`rx_valid`) and treats the top two bits as an opcode. It keeps separate write and read address pointers, performs memory writes, and returns read data to the slave on `tx_data`/`tx_valid` for serialisation onto MISO.

## Interface
Parameters:
- `MEM_DEPTH`, 256: number of 8-bit words; legal range 2..2^`ADDR_SIZE`.
- `ADDR_SIZE`, 8: pointer width; fixed at 8 because the address field of `din` is 8 bits.
- `AUTO_INC`, 0: when 1, a pointer advances after each data access.

Ports:
- `clk`, in, 1: single clock; everything is rising-edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `din`, in, 10: command word from the SPI slave (`rx_data`); `[9:8]` is the opcode and `[7:0]` is the payload.
- `rx_valid`, in, 1: `din` is valid.
- `dout`, out, 8: read data to the slave (`tx_data`).
- `tx_valid`, out, 1: one-cycle pulse; `dout` is valid.
- `addr_err`, out, 1: sticky flag for an out-of-range access.

## Operation
- **Command acceptance.** A command is accepted on the first cycle in which `rx_valid` is 1 and the previous-cycle registered `rx_valid` was 0. This is a rising-edge detect. If `rx_valid` is held high, the block acts exactly once.
- **Opcode 00, WR_ADDR.** `wr_ptr <= din[7:0]`.
- **Opcode 01, WR_DATA.**
  - If `wr_ptr < MEM_DEPTH`: `mem[wr_ptr] <= din[7:0]`.
  - Otherwise the write is dropped and `addr_err <= 1`.
  - If `AUTO_INC`: `wr_ptr <= (wr_ptr == MEM_DEPTH-1) ? 0 : wr_ptr+1`.
- **Opcode 10, RD_ADDR.** `rd_ptr <= din[7:0]`.
- **Opcode 11, RD_DATA.**
  - If `rd_ptr < MEM_DEPTH`: `dout <= mem[rd_ptr]`.
  - Otherwise `dout <= 8'h00` and `addr_err <= 1`.
  - `tx_valid <= 1` for exactly one cycle in both cases.
  - If `AUTO_INC`: `rd_ptr` advances with the same wrap rule as `wr_ptr`.
- **Pointers.** The two pointers are independent. A read never modifies `wr_ptr`, and a write never modifies `rd_ptr`.
- **`addr_err`.** Cleared only by reset.
- **Control FSM.** Two states:
  - IDLE: waits for an accepted command. An accepted RD_DATA moves to RESP.
  - RESP: asserts `tx_valid` and returns unconditionally to IDLE.
  - A new accepted command arriving while in RESP is decoded normally, so back-to-back reads produce back-to-back pulses.

## Timing
- **Reset.** Reset is asynchronous and takes effect immediately. It clears `dout` to 0, `tx_valid` to 0, `addr_err` to 0, `wr_ptr` to 0, `rd_ptr` to 0, the FSM to IDLE, and the registered `rx_valid` to 0.
- **Memory contents.** Not reset; they are undefined after power-up.
- **Command latency.** A command accepted at edge N takes effect at edge N+1: pointer update, memory write, or `dout`/`tx_valid`. `tx_valid` is high for the cycle between edges N+1 and N+2.
- **Write-then-read ordering.** A WR_DATA at edge N followed by an RD_DATA to the same address at any later edge returns the new value. The read sees write-first ordering across commands.
- **Slave handshake.**
  - The slave loads `tx_data` while `tx_valid` is high, so `dout` is held stable until the next RD_DATA or reset.
  - `tx_valid` never stays high for more than one cycle per RD_DATA.
- **Reset mid-response.** If `rst_n` falls while `tx_valid` is high, `tx_valid` drops asynchronously and no response is replayed after reset.
- **Simultaneous events.** At most one command arrives per cycle, so there are no simultaneous memory ports. An RD_ADDR and an RD_DATA cannot collide.

## Structure
- **Shared package `spi_ram_pkg`.** Holds:
  - the opcode constants `OP_WR_ADDR=2'b00`, `OP_WR_DATA=2'b01`, `OP_RD_ADDR=2'b10`, `OP_RD_DATA=2'b11`;
  - the FSM state constants;
  - the command word width (10) and data width (8).
- **Sub-module `ram_sp_array`.** Contains the storage array with one synchronous port (`we`, `addr`, `wdata`, `rdata`) and no reset on the array. This keeps it inferable as block RAM.
- **Top level.** Contains the edge detect, decode, pointers, range check, FSM, and output registers.

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-cycle -> all outputs 0 immediately; `tx_valid` stays 0 for 5 cycles after release.
2. **Basic write then read.** Send `din`=`10'h0_12` (WR_ADDR 0x12), then `10'h1_A5` (WR_DATA 0xA5), then `10'h2_12` (RD_ADDR 0x12), then `10'h3_00` (RD_DATA), with `rx_valid` pulsed once each -> one cycle after the last, `dout`=0xA5 with a single-cycle `tx_valid`; `addr_err`=0.
3. **Held `rx_valid`.** Hold `rx_valid` high for 4 cycles with `din`=`10'h3_00` -> exactly one `tx_valid` pulse.
4. **AUTO_INC wrap.** With `AUTO_INC`=1 and `MEM_DEPTH`=256, set WR_ADDR 0xFF, then write 0x11 and 0x22 -> `mem[0xFF]`=0x11, `mem[0x00]`=0x22; reading from RD_ADDR 0xFF twice returns 0x11 then 0x22.
5. **Out-of-range access.** With `MEM_DEPTH`=200, send WR_ADDR 0xC8 and WR_DATA 0x55, then RD_ADDR 0xC8 and RD_DATA -> memory is unchanged, `dout`=0x00, `tx_valid` pulses, and `addr_err`=1 until reset.
6. **Reset mid-response.** Drop `rst_n` during the `tx_valid` cycle of an RD_DATA -> `tx_valid` falls immediately; the pointers read 0, so a subsequent RD_DATA reads `mem[0]`.
